cs_input_port: RTL and testbench

CS_INPUT_PORT -- requirements
Module: cs_input_port

---
 rtl/cs_input_port.sv | 137 +++++++++++++
 tb/tb_cs_input_port.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cs_input_port.sv
// cs_input_port: router input port with a flit FIFO, XY route computation and
// a per-packet route-hold FSM feeding the crossbar demux.
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   data_i, valid_i     upstream flit and its valid
//   ready_o             FIFO has room (count < DEPTH)
//   data_o, sel_o       head flit and held output-port select (111 = none)
//   valid_o, ready_i    routed-flit handshake with the output port
//   err_o               one-cycle pulse when a stray body/tail flit is dropped
module cs_input_port #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROUTER_X = 0,
  parameter int unsigned ROUTER_Y = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] data_o,
  output logic [2:0]  sel_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [1:0]  RX = 2'(ROUTER_X);
  localparam logic [1:0]  RY = 2'(ROUTER_Y);

  localparam logic [2:0] SEL_N    = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b001;
  localparam logic [2:0] SEL_W    = 3'b010;
  localparam logic [2:0] SEL_E    = 3'b011;
  localparam logic [2:0] SEL_L    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [2:0]    sel_q;
  logic          err_q;

  logic          empty;
  logic [15:0]   head;
  logic [1:0]    head_type;
  logic          head_is_end;
  logic          push;
  logic          pop;
  logic [2:0]    route;

  assign empty       = (count == '0);
  assign head        = mem[rd_ptr];
  assign head_type   = head[15:14];
  // single (00) and tail (11) both close a packet
  assign head_is_end = (head_type == 2'b00) || (head_type == 2'b11);

  assign ready_o = (count < CW'(DEPTH));
  assign push    = valid_i && ready_o;
  // IDLE pops only to discard a body/tail that arrived without a head
  assign pop     = !empty && (((state == ACTIVE) && ready_i) ||
                              ((state == IDLE) && head_type[1]));

  assign valid_o = (state == ACTIVE) && !empty;
  assign data_o  = valid_o ? head : 16'h0000;
  assign sel_o   = sel_q;
  assign err_o   = err_q;

  // Dimension-ordered XY route from the head flit's destination
  always_comb begin
    route = SEL_L;
    if (head[13:12] > RX)      route = SEL_E;
    else if (head[13:12] < RX) route = SEL_W;
    else if (head[11:10] < RY) route = SEL_N;
    else if (head[11:10] > RY) route = SEL_S;
  end

  // Flit storage; contents are don't-care while count is zero
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Route-hold FSM with registered select and error pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      sel_q <= SEL_NONE;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (!head_type[1]) begin
              sel_q <= route;
              state <= ACTIVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (pop && head_is_end) begin
            sel_q <= SEL_NONE;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          sel_q <= SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_input_port.sv
// Directed bench for cs_input_port (DEPTH 4, router at 1,1) with a scoreboard
// of expected {sel, data} transfers.
module tb_cs_input_port;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic [2:0]  sel_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] S_W = 3'b010, S_E = 3'b011, S_L = 3'b100, S_NONE = 3'b111;

  cs_input_port #(.DEPTH(4), .ROUTER_X(1), .ROUTER_Y(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .sel_o(sel_o), .valid_o(valid_o),
    .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Score any transfer presented this cycle, then advance to the next negedge
  task automatic cycle();
    exp_t e;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk("xfer_data", data_o, e.data);
        chk("xfer_sel", 16'(sel_o), 16'(e.sel));
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk(tag, 16'(sb.size()), 16'd0);
  endtask

  task automatic push_exp(input logic [2:0] s, input logic [15:0] d);
    exp_t e;
    e.sel  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 16'(ready_o), 16'd1);
    chk({tag, "_valid"}, 16'(valid_o), 16'd0);
    chk({tag, "_sel"},   16'(sel_o),   16'(S_NONE));
    chk({tag, "_err"},   16'(err_o),   16'd0);
    chk({tag, "_data"},  data_o,       16'h0000);
  endtask

  initial begin
    logic [15:0] bad [2];
    bad[0] = 16'h8123;
    bad[1] = 16'hC0FF;

    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 16'h0000;
    @(negedge clk_i);
    chk_reset_outs("reset");
    rst_n_i = 1'b1;
    cycle();

    // Single flit routed west with two-cycle latency
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 16'h0C00; push_exp(S_W, 16'h0C00);
    cycle();
    valid_i = 1'b0;
    chk("single_lat_e0_valid", 16'(valid_o), 16'd0);
    cycle();
    chk("single_lat_e1_valid", 16'(valid_o), 16'd1);
    chk("single_lat_e1_sel", 16'(sel_o), 16'(S_W));
    cycle();
    chk("single_done_sel", 16'(sel_o), 16'(S_NONE));
    chk("single_done_valid", 16'(valid_o), 16'd0);
    chk("single_sb", 16'(sb.size()), 16'd0);

    // Three-flit packet east, held while output stalled
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 16'h6400; push_exp(S_E, 16'h6400); cycle();
    data_i = 16'h8001; push_exp(S_E, 16'h8001); cycle();
    data_i = 16'hC002; push_exp(S_E, 16'hC002); cycle();
    valid_i = 1'b0;
    cycle();
    chk("pkt_hold_sel", 16'(sel_o), 16'(S_E));
    chk("pkt_hold_valid", 16'(valid_o), 16'd1);
    chk("pkt_hold_data", data_o, 16'h6400);
    ready_i = 1'b1;
    drain("pkt_drain");
    chk("pkt_idle_sel", 16'(sel_o), 16'(S_NONE));

    // Full FIFO: fifth push refused, pop with push pending, head-like body bits
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 16'h6400; push_exp(S_E, 16'h6400); cycle();
    data_i = 16'h8001; push_exp(S_E, 16'h8001); cycle();
    data_i = 16'h8002; push_exp(S_E, 16'h8002); cycle();
    chk("full_3_ready", 16'(ready_o), 16'd1);
    data_i = 16'hBC03; push_exp(S_E, 16'hBC03); cycle();
    chk("full_4_ready", 16'(ready_o), 16'd0);
    data_i = 16'h8FFF; cycle();
    chk("full_5_refused_ready", 16'(ready_o), 16'd0);
    ready_i = 1'b1; cycle();
    chk("full_pop_ready", 16'(ready_o), 16'd1);
    data_i = 16'h8004; push_exp(S_E, 16'h8004); cycle();
    chk("full_pushpop_ready", 16'(ready_o), 16'd1);
    ready_i = 1'b0;
    data_i = 16'hC005; push_exp(S_E, 16'hC005); cycle();
    chk("full_again_ready", 16'(ready_o), 16'd0);
    chk("full_body_sel", 16'(sel_o), 16'(S_E));
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain("full_drain");
    chk("full_idle_sel", 16'(sel_o), 16'(S_NONE));

    // Stray body/tail flits in IDLE are dropped with a one-cycle error pulse
    for (int k = 0; k < 2; k++) begin
      valid_i = 1'b1; data_i = bad[k]; cycle();
      valid_i = 1'b0;
      chk("drop_e0_err", 16'(err_o), 16'd0);
      cycle();
      chk("drop_err_pulse", 16'(err_o), 16'd1);
      chk("drop_valid", 16'(valid_o), 16'd0);
      cycle();
      chk("drop_err_clear", 16'(err_o), 16'd0);
      chk("drop_valid_after", 16'(valid_o), 16'd0);
      chk("drop_ready", 16'(ready_o), 16'd1);
    end

    // Local head, then asynchronous reset mid-packet
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 16'h5400; cycle();
    data_i = 16'h8001; cycle();
    valid_i = 1'b0;
    chk("local_sel", 16'(sel_o), 16'(S_L));
    chk("local_valid", 16'(valid_o), 16'd1);
    #2 rst_n_i = 1'b0;
    #1 chk_reset_outs("async_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cycle();
    chk("post_rst_valid", 16'(valid_o), 16'd0);
    chk("post_rst_sel", 16'(sel_o), 16'(S_NONE));

    // First flit after reset is routed from a fresh, empty FIFO
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 16'h0C00; push_exp(S_W, 16'h0C00); cycle();
    valid_i = 1'b0;
    chk("post_rst_e0_valid", 16'(valid_o), 16'd0);
    cycle();
    chk("post_rst_e1_sel", 16'(sel_o), 16'(S_W));
    drain("post_rst_drain");
    cycle();
    chk("post_rst_empty_valid", 16'(valid_o), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
